// File: rtl/hack_memory.sv
`default_nettype none
// ============================================================================
//  Module      : hack_memory
//  Description : Hack computer memory subsystem. Holds the 16K data RAM, 8K
//                screen RAM, the 32K loader-writable instruction ROM and the
//                keyboard buffer. CPU reads are combinational, the display
//                scanner port is registered (read-before-write), and a CPU
//                write to an unmapped address raises a one-cycle addr_err.
//                Optional build macro HACK_KBD_FIFO_EN: keyboard storage
//                becomes a 4-entry FIFO instead of a single key register.
//  Revision    : 1.0 - initial release
// ============================================================================
module hack_memory (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] inM,
    input  logic [15:0] pcaddr,
    output logic [15:0] instruction,
    input  logic        rom_we,
    input  logic [14:0] rom_addr,
    input  logic [15:0] rom_data,
    input  logic [12:0] scr_addr,
    output logic [15:0] scr_data,
    input  logic [15:0] kbd_code,
    input  logic        kbd_valid,
    output logic        kbd_ready,
    output logic        addr_err
);

    localparam logic [15:0] c_KBD_ADDR = 16'h6000;

    logic [15:0] r_ram    [0:16383];
    logic [15:0] r_screen [0:8191];
    logic [15:0] r_rom    [0:32767];

    logic [15:0] r_scr_data;
    logic        r_addr_err;

    logic        w_ram_sel;
    logic        w_scr_sel;
    logic        w_kbd_sel;
    logic        w_unmapped;
    logic        w_ram_we;
    logic        w_scr_we;
    logic        w_rom_we;
    logic        w_pop;
    logic        w_push;
    logic [15:0] w_kbd_head;

    assign w_ram_sel  = (addressM[15:14] == 2'b00);
    assign w_scr_sel  = (addressM[15:13] == 3'b010);
    assign w_kbd_sel  = (addressM == c_KBD_ADDR);
    assign w_unmapped = (addressM > c_KBD_ADDR);

    // Writes are gated by reset_n so an edge seen while reset is held
    // cannot corrupt storage.
    assign w_ram_we = reset_n & writeM & w_ram_sel;
    assign w_scr_we = reset_n & writeM & w_scr_sel;
    assign w_rom_we = reset_n & rom_we;

    // Keyboard pop comes from a CPU write to the key register; a zero key
    // code completes the handshake but is not stored.
    assign w_pop  = writeM & w_kbd_sel;
    assign w_push = kbd_valid & kbd_ready & (kbd_code != 16'h0000);

    // Data RAM write port (contents survive reset)
    always_ff @(posedge clk) begin
        if (w_ram_we) r_ram[addressM[13:0]] <= outM;
    end

    // Screen RAM write port (contents survive reset)
    always_ff @(posedge clk) begin
        if (w_scr_we) r_screen[addressM[12:0]] <= outM;
    end

    // Instruction ROM loader port (contents survive reset)
    always_ff @(posedge clk) begin
        if (w_rom_we) r_rom[rom_addr] <= rom_data;
    end

    // CPU read data mux: RAM, screen, key register, else zero
    always_comb begin
        inM = 16'h0000;
        if (w_ram_sel)      inM = r_ram[addressM[13:0]];
        else if (w_scr_sel) inM = r_screen[addressM[12:0]];
        else if (w_kbd_sel) inM = w_kbd_head;
    end

    // Upper half of the instruction space is empty and reads as zero
    assign instruction = pcaddr[15] ? 16'h0000 : r_rom[pcaddr[14:0]];

    // Scanner read register and unmapped-write error pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scr_data <= 16'h0000;
            r_addr_err <= 1'b0;
        end else begin
            r_scr_data <= r_screen[scr_addr];
            r_addr_err <= writeM & w_unmapped;
        end
    end

    assign scr_data = r_scr_data;
    assign addr_err = r_addr_err;

`ifdef HACK_KBD_FIFO_EN
    logic [15:0] r_fifo [0:3];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;
    logic        w_do_pop;

    assign kbd_ready  = (r_count < 3'd4);
    assign w_do_pop   = w_pop & (r_count != 3'd0);
    assign w_kbd_head = (r_count != 3'd0) ? r_fifo[r_rd_ptr] : 16'h0000;

    // Four-entry key FIFO; push and pop may both happen on one edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
            for (int i = 0; i < 4; i++) r_fifo[i] <= 16'h0000;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= kbd_code;
                r_wr_ptr         <= r_wr_ptr + 2'd1;
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_push, w_do_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    logic [15:0] r_kbd_reg;
    logic        r_kbd_full;

    assign kbd_ready  = ~r_kbd_full;
    assign w_kbd_head = r_kbd_full ? r_kbd_reg : 16'h0000;

    // Single key register; a push on the same edge as a pop wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_kbd_reg  <= 16'h0000;
            r_kbd_full <= 1'b0;
        end else if (w_push) begin
            r_kbd_reg  <= kbd_code;
            r_kbd_full <= 1'b1;
        end else if (w_pop) begin
            r_kbd_reg  <= 16'h0000;
            r_kbd_full <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire
